squash_game_ctrl: RTL and testbench
===================================

# squash_game_ctrl

Game-sequencing controller for the solo squash core. It owns the match lifecycle: attract, serve countdown, play, miss penalty and game over. It keeps a 2-digit BCD score and a lives counter, and gates ball motion. It also schedules speaker tone bursts. It sits beside the game datapath in the top level, consumes the already-synchronized control inputs plus collision pulses, and emits run/serve enables and display/sound controls.

## Interface
Parameters:
- `LIVES`, 3: lives per game (1-3).
- `SERVE_FRAMES`, 60: frames the ball is held before launch.
- `MISS_FRAMES`, 30: frames of penalty pause after a miss.
- `TONE_FRAMES`, 4: length of the hit/wall tone burst, in frames.

Ports:
- `clk`, in, 1: pixel clock, the only clock.
- `reset`, in, 1: **synchronous, active-high** reset.
- `vsync`, in, 1: active-low vertical sync from the VGA timing; used as the frame reference.
- `new_game`, in, 1: synchronized level, active-high.
- `pause`, in, 1: synchronized level, active-high.
- `hit`, in, 1: one-cycle pulse, ball struck paddle.
- `wall`, in, 1: one-cycle pulse, ball struck a wall.
- `miss`, in, 1: one-cycle pulse, ball passed paddle.
- `run`, out, 1: ball motion enable.
- `serve`, out, 1: one-cycle pulse; datapath re-centres the ball.
- `score`, out, 8: BCD, `[7:4]` tens, `[3:0]` units.
- `lives`, out, 2: remaining lives.
- `game_over`, out, 1: high in the OVER state.
- `tone_sel`, out, 2: 0 = silent, 1 = low (wall), 2 = high (hit), 3 = buzz (miss).

## Operation
- Frame tick: one-cycle internal pulse on the first cycle `vsync` is sampled 0 after being sampled 1. All frame counters decrement only on a tick.
- ATTRACT is the reset state.
  - `run`=0, `score`=0, `lives`=0, `game_over`=0, `tone_sel`=0.
- `new_game` high in any state:
  - Next state SERVE.
  - `lives`←LIVES, `score`←0, `serve` pulses once, frame counter←SERVE_FRAMES.
  - `new_game` held high re-arms every cycle, so the controller stays in SERVE with no further `serve` pulses after the first. The rising edge is detected internally.
- SERVE: `run`=0. When the counter reaches 0 on a tick → PLAY.
- PLAY: `run` = ~`pause`.
  - While `pause`=1, the `hit`/`wall`/`miss` inputs are ignored and the tone counter freezes.
  - `hit`: score increments in BCD (09→10, 99 saturates at 99). `tone_sel`←2 for TONE_FRAMES ticks.
  - `wall`: `tone_sel`←1 for TONE_FRAMES ticks, unless a hit tone is active.
  - `miss`: `lives`←`lives`-1 and `tone_sel`←3.
    - If the result is 0 → OVER.
    - Otherwise → MISS, with counter←MISS_FRAMES.
- MISS: `run`=0, buzz continues.
  - At counter 0 → SERVE with a `serve` pulse and counter←SERVE_FRAMES.
  - `tone_sel`←0 on exit.
- OVER: `run`=0, `game_over`=1, buzz for MISS_FRAMES ticks then silent. The score is held.
- Priority for simultaneous pulses: `miss` > `hit` > `wall`. A hit in the same cycle as a miss does not score.
- `hit`, `wall` and `miss` outside PLAY are ignored.
- A new tone request restarts the tone counter. Tone priority is buzz > high > low.

## Timing
- All outputs are registered.
- Event → output latency: `score`, `lives`, `tone_sel` and the state change are visible 1 cycle after the input pulse.
- `run` drops the cycle after a `miss`, or the cycle after `pause` is sampled high.
- `serve` is high for exactly 1 cycle, coincident with the state register entering SERVE.
- Frame tick latency: 2 cycles after the `vsync` falling edge, due to the edge register.
- Reset mid-game: on the next edge, every output takes its ATTRACT value. Reset dominates `new_game`.
- Counters are sized for the parameter maximum (8 bits). Counter reload happens on state entry; expiry is checked on a tick.

## Structure
- Shared package `squash_pkg`: state enum (ATTRACT, SERVE, PLAY, MISS, OVER), `tone_sel` encodings, and default parameter constants.
- Sub-module `bcd_counter2`: 2-digit saturating BCD incrementer with sync clear.
- The vsync edge detect stays inline.

## Test plan
- Reset, then `new_game` pulse → one `serve` pulse. `run`=0 for exactly 60 ticks, then `run`=1, `lives`=3, `score`=0x00.
- In PLAY, 10 `hit` pulses → `score`=0x10. The 100th hit leaves `score`=0x99. Each hit gives `tone_sel`=2 for 4 ticks.
- 3 `miss` pulses, each followed by a full MISS/SERVE cycle → `lives` 2, 1, 0. After the third, `game_over`=1, `run`=0, `tone_sel`=3 for 30 ticks then 0.
- `hit` and `miss` in the same cycle → `score` unchanged, `lives` decremented, `tone_sel`=3. `wall` during an active hit tone → `tone_sel` stays 2.
- `pause` high in PLAY → `run`=0 next cycle, and a `hit` pulse is ignored. On release, the tone counter resumes from its frozen value.
- `reset` asserted mid-MISS → next cycle `score`=0, `lives`=0, `tone_sel`=0, ATTRACT. Simultaneous `reset`+`new_game` → ATTRACT.

Source files
------------

// File: rtl/squash_pkg.sv
// Shared types and constants for the squash game sequencing controller.
// Also holds the saturating two-digit BCD increment used by the score counter.
package squash_pkg;

  typedef enum logic [2:0] {
    ST_ATTRACT = 3'd0,
    ST_SERVE   = 3'd1,
    ST_PLAY    = 3'd2,
    ST_MISS    = 3'd3,
    ST_OVER    = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    TONE_OFF  = 2'd0,
    TONE_LOW  = 2'd1,
    TONE_HIGH = 2'd2,
    TONE_BUZZ = 2'd3
  } tone_e;

  localparam int unsigned DEF_LIVES        = 32'd3;
  localparam int unsigned DEF_SERVE_FRAMES = 32'd60;
  localparam int unsigned DEF_MISS_FRAMES  = 32'd30;
  localparam int unsigned DEF_TONE_FRAMES  = 32'd4;

  // Adds one to a two-digit BCD value, holding at 99.
  function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h99) begin
      r = v;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/squash_game_ctrl_bcd.sv
// Two-digit saturating BCD score counter with synchronous clear.
module bcd_counter2
  import squash_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] score
);

  logic [7:0] score_r;

  // Score register: clear wins over increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      score_r <= 8'h00;
    end else if (clr) begin
      score_r <= 8'h00;
    end else if (inc) begin
      score_r <= bcd_inc_sat(score_r);
    end else begin
      score_r <= score_r;
    end
  end

  assign score = score_r;

endmodule

// File: rtl/squash_game_ctrl.sv
// Match lifecycle controller for the solo squash core: attract, serve, play,
// miss penalty and game over, plus score, lives and tone-burst scheduling.
module squash_game_ctrl
  import squash_pkg::*;
#(
  parameter int unsigned LIVES        = DEF_LIVES,
  parameter int unsigned SERVE_FRAMES = DEF_SERVE_FRAMES,
  parameter int unsigned MISS_FRAMES  = DEF_MISS_FRAMES,
  parameter int unsigned TONE_FRAMES  = DEF_TONE_FRAMES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       new_game,
  input  logic       pause,
  input  logic       hit,
  input  logic       wall,
  input  logic       miss,
  output logic       run,
  output logic       serve,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic       game_over,
  output logic [1:0] tone_sel
);

  localparam logic [7:0] SERVE_CNT = 8'(SERVE_FRAMES);
  localparam logic [7:0] MISS_CNT  = 8'(MISS_FRAMES);
  localparam logic [7:0] TONE_CNT  = 8'(TONE_FRAMES);
  localparam logic [1:0] LIVES_CNT = 2'(LIVES);

  state_e     state_r;
  logic [7:0] cnt_r;
  logic [7:0] tone_cnt_r;
  tone_e      tone_sel_r;
  logic [1:0] lives_r;
  logic       run_r;
  logic       serve_r;
  logic       game_over_r;
  logic       vsync_r;
  logic       tick_r;
  logic       new_game_d_r;

  logic       play_live_s;
  logic       miss_s;
  logic       hit_s;
  logic       wall_s;
  logic       cnt_exp_s;

  // Gameplay events qualify only in unpaused PLAY; miss beats hit beats wall.
  always_comb begin
    play_live_s = (state_r == ST_PLAY) && !pause && !new_game;
    miss_s      = play_live_s && miss;
    hit_s       = play_live_s && hit && !miss;
    wall_s      = play_live_s && wall && !miss && !hit && (tone_sel_r != TONE_HIGH);
    if (tick_r && (cnt_r <= 8'd1)) begin
      cnt_exp_s = 1'b1;
    end else begin
      cnt_exp_s = 1'b0;
    end
  end

  bcd_counter2 u_score (
    .clk   (clk),
    .reset (reset),
    .clr   (new_game),
    .inc   (hit_s),
    .score (score)
  );

  // Frame tick, lifecycle FSM and every registered control output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_ATTRACT;
      cnt_r        <= 8'd0;
      tone_cnt_r   <= 8'd0;
      tone_sel_r   <= TONE_OFF;
      lives_r      <= 2'd0;
      run_r        <= 1'b0;
      serve_r      <= 1'b0;
      game_over_r  <= 1'b0;
      vsync_r      <= 1'b0;
      tick_r       <= 1'b0;
      new_game_d_r <= 1'b0;
    end else begin
      vsync_r      <= vsync;
      tick_r       <= vsync_r & ~vsync;
      new_game_d_r <= new_game;
      serve_r      <= 1'b0;
      if (new_game) begin
        // Held new_game keeps re-arming SERVE; only its rising edge serves.
        state_r     <= ST_SERVE;
        lives_r     <= LIVES_CNT;
        cnt_r       <= SERVE_CNT;
        serve_r     <= ~new_game_d_r;
        run_r       <= 1'b0;
        game_over_r <= 1'b0;
        tone_sel_r  <= TONE_OFF;
        tone_cnt_r  <= 8'd0;
      end else begin
        case (state_r)
          ST_ATTRACT: begin
            run_r       <= 1'b0;
            game_over_r <= 1'b0;
          end
          ST_SERVE: begin
            run_r <= 1'b0;
            if (cnt_exp_s) begin
              state_r <= ST_PLAY;
              run_r   <= ~pause;
            end else if (tick_r) begin
              cnt_r <= cnt_r - 8'd1;
            end else begin
              cnt_r <= cnt_r;
            end
          end
          ST_PLAY: begin
            if (miss_s) begin
              lives_r     <= lives_r - 2'd1;
              tone_sel_r  <= TONE_BUZZ;
              tone_cnt_r  <= 8'd0;
              cnt_r       <= MISS_CNT;
              run_r       <= 1'b0;
              state_r     <= (lives_r <= 2'd1) ? ST_OVER : ST_MISS;
              game_over_r <= (lives_r <= 2'd1);
            end else begin
              run_r <= ~pause;
              if (hit_s) begin
                tone_sel_r <= TONE_HIGH;
                tone_cnt_r <= TONE_CNT;
              end else if (wall_s) begin
                tone_sel_r <= TONE_LOW;
                tone_cnt_r <= TONE_CNT;
              end else if (tick_r && !pause && (tone_cnt_r != 8'd0)) begin
                tone_cnt_r <= tone_cnt_r - 8'd1;
                if (tone_cnt_r == 8'd1) begin
                  tone_sel_r <= TONE_OFF;
                end else begin
                  tone_sel_r <= tone_sel_r;
                end
              end else begin
                tone_cnt_r <= tone_cnt_r;
              end
            end
          end
          ST_MISS: begin
            run_r <= 1'b0;
            if (cnt_exp_s) begin
              state_r    <= ST_SERVE;
              serve_r    <= 1'b1;
              cnt_r      <= SERVE_CNT;
              tone_sel_r <= TONE_OFF;
            end else if (tick_r) begin
              cnt_r <= cnt_r - 8'd1;
            end else begin
              cnt_r <= cnt_r;
            end
          end
          ST_OVER: begin
            run_r       <= 1'b0;
            game_over_r <= 1'b1;
            if (cnt_exp_s) begin
              cnt_r      <= 8'd0;
              tone_sel_r <= TONE_OFF;
            end else if (tick_r) begin
              cnt_r <= cnt_r - 8'd1;
            end else begin
              cnt_r <= cnt_r;
            end
          end
          default: begin
            state_r     <= ST_ATTRACT;
            run_r       <= 1'b0;
            game_over_r <= 1'b0;
            tone_sel_r  <= TONE_OFF;
          end
        endcase
      end
    end
  end

  assign run       = run_r;
  assign serve     = serve_r;
  assign lives     = lives_r;
  assign game_over = game_over_r;
  assign tone_sel  = tone_sel_r;

endmodule

// File: tb/tb_squash_game_ctrl.sv
// Directed plus randomized bench for squash_game_ctrl, checked every cycle
// against a frame-level behavioural model of the game rules.
module tb_squash_game_ctrl;

  localparam int M_ATTRACT = 0;
  localparam int M_SERVE   = 1;
  localparam int M_PLAY    = 2;
  localparam int M_MISS    = 3;
  localparam int M_OVER    = 4;
  localparam int FRAME_LEN = 10;

  logic clk = 1'b0;
  logic reset, vsync, new_game, pause, hit, wall, miss;
  logic run, serve, game_over;
  logic [7:0] score;
  logic [1:0] lives, tone_sel;

  int tests = 0;
  int failed = 0;
  int cyc = 0;

  // behavioural model state
  int m_mode, m_score, m_lives, m_tone, m_tone_left, m_frames;
  bit m_run, m_serve, m_over;
  bit last_vs, tick_due, ng_prev;

  squash_game_ctrl #(
    .LIVES(3), .SERVE_FRAMES(60), .MISS_FRAMES(30), .TONE_FRAMES(4)
  ) dut (
    .clk(clk), .reset(reset), .vsync(vsync), .new_game(new_game),
    .pause(pause), .hit(hit), .wall(wall), .miss(miss),
    .run(run), .serve(serve), .score(score), .lives(lives),
    .game_over(game_over), .tone_sel(tone_sel)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock edge of the game rules, using the inputs present at the edge.
  task automatic model_edge();
    bit tick;
    if (reset) begin
      m_mode = M_ATTRACT; m_score = 0; m_lives = 0; m_tone = 0; m_tone_left = 0;
      m_frames = 0; m_serve = 0; last_vs = 0; tick_due = 0; ng_prev = 0;
    end else begin
      tick = tick_due;
      tick_due = last_vs && !vsync;
      last_vs = vsync;
      m_serve = 0;
      if (new_game) begin
        m_serve = !ng_prev;
        m_mode = M_SERVE; m_lives = 3; m_score = 0; m_frames = 60;
        m_tone = 0; m_tone_left = 0;
      end else begin
        case (m_mode)
          M_SERVE: if (tick) begin
            m_frames--;
            if (m_frames <= 0) m_mode = M_PLAY;
          end
          M_PLAY: if (!pause) begin
            if (miss) begin
              m_lives--; m_tone = 3; m_frames = 30;
              m_mode = (m_lives == 0) ? M_OVER : M_MISS;
            end else if (hit) begin
              m_score = (m_score < 99) ? m_score + 1 : 99;
              m_tone = 2; m_tone_left = 4;
            end else if (wall && m_tone != 2) begin
              m_tone = 1; m_tone_left = 4;
            end else if (tick && m_tone != 0) begin
              m_tone_left--;
              if (m_tone_left == 0) m_tone = 0;
            end
          end
          M_MISS: if (tick) begin
            m_frames--;
            if (m_frames <= 0) begin
              m_mode = M_SERVE; m_serve = 1; m_frames = 60; m_tone = 0;
            end
          end
          M_OVER: if (tick && m_frames > 0) begin
            m_frames--;
            if (m_frames == 0) m_tone = 0;
          end
          default: ;
        endcase
      end
      ng_prev = new_game;
    end
    m_run  = (m_mode == M_PLAY) && !pause;
    m_over = (m_mode == M_OVER);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("run", 8'(run), 8'(m_run));
    chk("serve", 8'(serve), 8'(m_serve));
    chk("score", score, to_bcd(m_score));
    chk("lives", 8'(lives), 8'(m_lives));
    chk("game_over", 8'(game_over), 8'(m_over));
    chk("tone_sel", 8'(tone_sel), 8'(m_tone));
    cyc++;
    vsync = ((cyc % FRAME_LEN) < 8) ? 1'b1 : 1'b0;
  endtask

  task automatic wait_mode(input int target, input int budget);
    int n = 0;
    while (m_mode != target && n < budget) begin
      step();
      n++;
    end
    if (m_mode != target) begin
      tests++;
      failed++;
      $error("FAIL wait_mode: reached mode %0d expected %0d", m_mode, target);
    end
  endtask

  task automatic pulse_hit(input bit with_wall);
    hit = 1'b1; wall = with_wall;
    step();
    hit = 1'b0; wall = 1'b0;
  endtask

  initial begin
    reset = 1'b1; vsync = 1'b1; new_game = 1'b0; pause = 1'b0;
    hit = 1'b0; wall = 1'b0; miss = 1'b0;
    repeat (3) step();
    chk("rst_score", score, 8'h00);
    chk("rst_tone", 8'(tone_sel), 8'd0);
    reset = 1'b0;
    repeat (4) step();

    // First game: one serve pulse, then 60 frames held before play.
    new_game = 1'b1; step(); new_game = 1'b0;
    chk("first_serve", 8'(serve), 8'd1);
    wait_mode(M_PLAY, 2000);
    step();
    chk("play_run", 8'(run), 8'd1);
    chk("play_lives", 8'(lives), 8'd3);

    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 6)) step();
      pulse_hit($urandom_range(0, 3) == 0);
    end
    chk("score_10", score, 8'h10);

    // Paused play ignores hits and freezes the tone countdown.
    pulse_hit(1'b0);
    pause = 1'b1; step();
    chk("pause_run", 8'(run), 8'd0);
    pulse_hit(1'b0);
    chk("pause_hit", score, 8'h11);
    repeat (25) step();
    pause = 1'b0;
    repeat (25) step();

    for (int i = 0; i < 89; i++) begin
      repeat ($urandom_range(0, 2)) step();
      pulse_hit($urandom_range(0, 4) == 0);
    end
    chk("score_99", score, 8'h99);
    repeat (3) pulse_hit(1'b0);
    chk("score_sat", score, 8'h99);

    // A wall during an active hit tone keeps the high tone.
    pulse_hit(1'b0);
    wall = 1'b1; step(); wall = 1'b0;
    chk("wall_under_hit", 8'(tone_sel), 8'd2);

    // Hit and miss together: no score, one life lost, buzz.
    hit = 1'b1; miss = 1'b1; step(); hit = 1'b0; miss = 1'b0;
    chk("hm_score", score, 8'h99);
    chk("hm_lives", 8'(lives), 8'd2);
    chk("hm_tone", 8'(tone_sel), 8'd3);
    wait_mode(M_SERVE, 2000);
    wait_mode(M_PLAY, 2000);
    repeat (5) step();
    miss = 1'b1; step(); miss = 1'b0;
    chk("lives_1", 8'(lives), 8'd1);
    wait_mode(M_SERVE, 2000);
    wait_mode(M_PLAY, 2000);
    repeat (5) step();
    miss = 1'b1; step(); miss = 1'b0;
    chk("lives_0", 8'(lives), 8'd0);
    chk("over_flag", 8'(game_over), 8'd1);
    repeat (30 * FRAME_LEN + 5) step();
    chk("over_silent", 8'(tone_sel), 8'd0);
    chk("over_score", score, 8'h99);

    // Held new_game gives a single serve pulse.
    new_game = 1'b1;
    repeat (5) step();
    new_game = 1'b0;
    wait_mode(M_PLAY, 2000);
    pulse_hit(1'b0);
    miss = 1'b1; step(); miss = 1'b0;
    repeat (20) step();
    reset = 1'b1; step(); reset = 1'b0;
    chk("rst_miss_score", score, 8'h00);
    chk("rst_miss_lives", 8'(lives), 8'd0);
    chk("rst_miss_tone", 8'(tone_sel), 8'd0);
    step();
    reset = 1'b1; new_game = 1'b1; step(); reset = 1'b0; new_game = 1'b0;
    chk("rst_ng_serve", 8'(serve), 8'd0);
    chk("rst_ng_lives", 8'(lives), 8'd0);
    repeat (3) step();

    // Randomized play against the model.
    for (int i = 0; i < 4000; i++) begin
      reset    = ($urandom_range(0, 1499) == 0);
      new_game = ($urandom_range(0, 299) == 0) ? 1'b1 : (new_game && $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 49) == 0) pause = ~pause;
      hit  = ($urandom_range(0, 7) == 0);
      wall = ($urandom_range(0, 7) == 0);
      miss = ($urandom_range(0, 149) == 0);
      step();
    end
    reset = 1'b0; new_game = 1'b0; pause = 1'b0;
    hit = 1'b0; wall = 1'b0; miss = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
